res_wb: RTL and testbench
=========================

# res_wb

Result write-back buffer for the 16-bit RISC datapath. It is the write side of the register path and the counterpart of the operand-latch registers that feed the ALU. ALU results, each tagged with a destination register, are queued in a small FIFO and drained into the register-file write port over a valid/ready handshake. A per-register `pending` mask lets the decoder stall operand fetch while a result for that register is still in flight.

## Interface
Parameters:
- `DW`, 16, result data width
- `AW`, 3, destination register address width (2**AW registers)
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2
- `LW`, $clog2(DEPTH)+1, width of `level` (derived; do not override)

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous discard of all queued results
- `in_valid`  in  1  ALU result present
- `in_ready`  out  1  buffer can accept a result this cycle
- `in_data`  in  DW  result value
- `in_dest`  in  AW  destination register
- `out_valid`  out  1  head entry valid toward the register file
- `out_ready`  in  1  register file accepts the head entry
- `out_data`  out  DW  head result value
- `out_dest`  out  AW  head destination register
- `level`  out  LW  number of queued entries, 0..DEPTH
- `pending`  out  2**AW  bit r set iff any queued entry has dest r

## Operation
- Push: `in_valid && in_ready` writes {`in_data`, `in_dest`} at the write pointer and advances it.
- Pop: `out_valid && out_ready` advances the read pointer.
- `in_ready = !full && !flush`. It has no combinational dependence on `out_ready`, so no push is accepted while full, even if a pop occurs in the same cycle.
- `out_valid = !empty`. When empty, `out_data` and `out_dest` read 0, never stale memory.
- Simultaneous push and pop on a non-empty, non-full buffer: `level` is unchanged and both pointers advance.
- Pointers are log2(DEPTH)+1 bits with natural wrap-around.
  - Full: the MSBs differ and the remaining bits are equal.
  - Empty: the pointers are equal.
- `flush` has priority over push and pop. At the next edge both pointers and `level` go to 0. `in_valid` and `out_ready` are ignored during the flush cycle.
- `pending` is a combinational OR of the one-hot decode of `dest` over the valid entries. It updates in the same cycle that `level` changes.
- Duplicate destinations are permitted. A bit stays set until the last entry with that dest pops.
- Holding `out_valid` and the head contents stable until accepted is the buffer's obligation. It must not withdraw or alter the head while it is unaccepted.

## Timing
- Reset (asynchronous assert, synchronous-safe release): pointers = 0, `level` = 0, `out_valid` = 0, `out_data` = 0, `out_dest` = 0, `pending` = 0, `in_ready` = 1. Memory contents are not reset.
- Latency: a push at edge N gives `out_valid` = 1 with that data after edge N (1 cycle, no bypass).
- Throughput: 1 push and 1 pop per cycle sustained.
- `level` and `pending` are valid after each edge. `in_ready` and `out_valid` are functions of registered state (and of `flush` for `in_ready`).
- Reset asserted mid-transfer: queued entries are lost and outputs return to their reset values immediately.

## Structure
- Shared package `risc_pkg`:
  - `DW` and `AW` defaults.
  - `wb_entry_t` typedef {data[DW], dest[AW]}.
- One natural sub-module, `res_fifo_mem`: DEPTH×(DW+AW) storage with a synchronous write port and an asynchronous read port.
- Pointer, level and pending logic stay in `res_wb`.

## Test plan
- Reset and idle: assert `rst_n` = 0 mid-run → `out_valid` = 0, `level` = 0, `pending` = 0, `in_ready` = 1, `out_data` = 0.
- Single pass: push {16'hA5A5, 3} with `out_ready` = 0 → `level` = 1, `pending` = 8'b0000_1000, `out_data` = A5A5, `out_dest` = 3. Then `out_ready` = 1 for 1 cycle → `level` = 0, `pending` = 0.
- Fill and backpressure: 5 back-to-back pushes with dests 1,2,3,4,5 and `out_ready` = 0 → `in_ready` drops after the 4th push, the 5th is not accepted, `level` = 4, `pending` = 8'b0001_1110. Drain → outputs in order 1,2,3,4.
- Duplicate dest: push dest 6 twice, then pop once → `pending[6]` is still 1. Pop again → `pending[6]` = 0.
- Streaming with wrap-around: 20 results with `in_valid` and `out_ready` both held high, data = index → every value is delivered exactly once in order, `level` ≤ 1, and the pointers wrap.
- Flush collision: `level` = 3, assert `flush` with `in_valid` = 1 and `out_ready` = 1 → next cycle `level` = 0, `out_valid` = 0, `pending` = 0, and no write occurs.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC datapath.
// The write-back entry layout is {data, dest}, with dest in the low bits.
package risc_pkg;

  localparam int DW = 16;
  localparam int AW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] dest;
  } wb_entry_t;

endpackage : risc_pkg

// File: rtl/res_fifo_mem.sv
// Storage array for the result write-back buffer.
// It has one synchronous write port and one asynchronous read port, and it
// exposes every slot's dest field so the pending mask can be built from it.
module res_fifo_mem #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 16,
  parameter  int DEST_W = 3,
  localparam int PW     = $clog2(DEPTH),
  localparam int W      = DATA_W + DEST_W
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [PW-1:0]           i_waddr,
  input  logic [W-1:0]            i_wdata,
  input  logic [PW-1:0]           i_raddr,
  output logic [W-1:0]            o_rdata,
  output logic [DEPTH*DEST_W-1:0] o_dests
);

  logic [W-1:0] r_mem [DEPTH];

  // NOTE: the storage array has no reset. Validity comes only from the
  //       pointers, so resetting the array would add a reset path to every bit
  //       for no functional gain.
  // NOTE: sequential state always uses <= so that every flop samples values
  //       from before the edge, regardless of the order of the statements.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

  for (genvar g = 0; g < DEPTH; g++) begin : g_dest
    assign o_dests[g*DEST_W +: DEST_W] = r_mem[g][DEST_W-1:0];
  end

endmodule : res_fifo_mem

// File: rtl/res_wb.sv
// Result write-back buffer. It queues tagged ALU results and drains them to
// the register-file write port, and it tracks which registers have a result in flight.
module res_wb #(
  parameter int DW    = risc_pkg::DW,
  parameter int AW    = risc_pkg::AW,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [AW-1:0]   in_dest,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [AW-1:0]   out_dest,
  output logic [LW-1:0]   level,
  output logic [2**AW-1:0] pending
);

  localparam int PW = $clog2(DEPTH);

  // This type has the same layout as risc_pkg::wb_entry_t, but its widths
  // follow this instance's parameters.
  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] dest;
  } entry_t;

  logic [PW:0]          r_wr_ptr, r_rd_ptr;
  logic                 w_full, w_empty, w_push, w_pop;
  logic [LW-1:0]        w_level;
  entry_t               w_wentry, w_rentry, w_head;
  logic [DEPTH*AW-1:0]  w_dests;
  logic [2**AW-1:0]     w_pending;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_level = LW'(r_wr_ptr - r_rd_ptr);

  assign in_ready  = !w_full && !flush;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready && !flush;

  assign w_wentry = '{data: in_data, dest: in_dest};

  res_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DW),
    .DEST_W (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[PW-1:0]),
    .i_wdata (w_wentry),
    .i_raddr (r_rd_ptr[PW-1:0]),
    .o_rdata (w_rentry),
    .o_dests (w_dests)
  );

  // When the buffer is empty, the outputs are zero instead of stale memory contents.
  assign w_head   = w_empty ? '0 : w_rentry;
  assign out_data = w_head.data;
  assign out_dest = w_head.dest;
  assign level    = w_level;

  // A slot is live when its distance from the read pointer is below the level.
  // NOTE: w_pending gets a default before the loop so that no path leaves it
  //       unassigned, which would otherwise infer a latch.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (LW'(PW'(PW'(i) - r_rd_ptr[PW-1:0])) < w_level)
        w_pending[w_dests[i*AW +: AW]] = 1'b1;
    end
  end
  assign pending = w_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule : res_wb

// File: tb/tb_res_wb.sv
// Directed self-checking bench for res_wb (DW=16, AW=3, DEPTH=4).
module tb_res_wb;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic [2:0]  in_dest, out_dest;
  logic [2:0]  level;
  logic [7:0]  pending;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  res_wb #(.DW(16), .AW(3), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_dest  (out_dest),
    .level     (level),
    .pending   (pending)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic [2:0] r);
    in_valid = 1'b1; in_data = d; in_dest = r;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    push(16'h1111, 3'd1);
    push(16'h2222, 3'd2);
    #3 rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (level !== 3'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", level); end
    n_vec++; if (pending !== 8'h00) begin n_bad++; $display("FAIL reset_pending got %h want 00", pending); end
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    n_vec++; if (out_dest !== 3'd0) begin n_bad++; $display("FAIL reset_out_dest got %0d want 0", out_dest); end
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    push(16'hA5A5, 3'd3);
    n_vec++; if (level !== 3'd1) begin n_bad++; $display("FAIL single_level got %0d want 1", level); end
    n_vec++; if (pending !== 8'b0000_1000) begin n_bad++; $display("FAIL single_pending got %b want 00001000", pending); end
    n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_out_valid got %b want 1", out_valid); end
    n_vec++; if (out_data !== 16'hA5A5) begin n_bad++; $display("FAIL single_out_data got %h want a5a5", out_data); end
    n_vec++; if (out_dest !== 3'd3) begin n_bad++; $display("FAIL single_out_dest got %0d want 3", out_dest); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    n_vec++; if (level !== 3'd0) begin n_bad++; $display("FAIL single_pop_level got %0d want 0", level); end
    n_vec++; if (pending !== 8'h00) begin n_bad++; $display("FAIL single_pop_pending got %h want 00", pending); end
    n_vec++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL single_empty_data got %h want 0000", out_data); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; in_data = 16'h0100 + 16'(k); in_dest = 3'(k);
      n_vec++;
      if (in_ready !== (k <= 4)) begin
        n_bad++; $display("FAIL fill_in_ready[%0d] got %b want %b", k, in_ready, (k <= 4));
      end
      cycle();
    end
    in_valid = 1'b0;
    n_vec++; if (level !== 3'd4) begin n_bad++; $display("FAIL fill_level got %0d want 4", level); end
    n_vec++; if (pending !== 8'b0001_1110) begin n_bad++; $display("FAIL fill_pending got %b want 00011110", pending); end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_dest !== 3'(k) || out_data !== 16'h0100 + 16'(k)) begin
        n_bad++;
        $display("FAIL drain[%0d] got v=%b d=%h r=%0d want v=1 d=%h r=%0d",
                 k, out_valid, out_data, out_dest, 16'h0100 + 16'(k), k);
      end
      cycle();
    end
    out_ready = 1'b0;
    n_vec++; if (level !== 3'd0) begin n_bad++; $display("FAIL drain_level got %0d want 0", level); end
  endtask

  task automatic test_dup_dest();
    out_ready = 1'b0;
    push(16'h0006, 3'd6);
    push(16'h0066, 3'd6);
    n_vec++; if (level !== 3'd2 || pending !== 8'h40) begin
      n_bad++; $display("FAIL dup_fill got level=%0d pend=%h want level=2 pend=40", level, pending);
    end
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
    n_vec++; if (pending !== 8'h40 || out_data !== 16'h0066) begin
      n_bad++; $display("FAIL dup_pop1 got pend=%h data=%h want pend=40 data=0066", pending, out_data);
    end
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
    n_vec++; if (pending !== 8'h00) begin n_bad++; $display("FAIL dup_pop2 got pend=%h want 00", pending); end
  endtask

  task automatic test_stream();
    int pushed = 0;
    int popped = 0;
    logic [7:0] exp_pend;
    logic push_now, pop_now;
    in_valid = 1'b1; in_data = 16'd0; in_dest = 3'd0; out_ready = 1'b1;
    for (int c = 0; c < 80 && popped < 20; c++) begin
      if (out_valid) begin
        n_vec++;
        if (out_data !== 16'(popped) || out_dest !== 3'(popped % 8)) begin
          n_bad++; $display("FAIL stream_data[%0d] got d=%0d r=%0d want d=%0d r=%0d",
                            popped, out_data, out_dest, popped, popped % 8);
        end
      end
      push_now = in_valid && in_ready;
      pop_now  = out_valid;
      cycle();
      if (push_now) pushed++;
      if (pop_now)  popped++;
      exp_pend = '0;
      for (int j = popped; j < pushed; j++) exp_pend[j % 8] = 1'b1;
      n_vec++;
      if (level !== 3'(pushed - popped) || level > 3'd1 || pending !== exp_pend) begin
        n_bad++; $display("FAIL stream_state[%0d] got level=%0d pend=%h want level=%0d pend=%h",
                          c, level, pending, pushed - popped, exp_pend);
      end
      in_valid = (pushed < 20);
      in_data  = 16'(pushed);
      in_dest  = 3'(pushed % 8);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_vec++; if (popped != 20) begin n_bad++; $display("FAIL stream_count got %0d want 20", popped); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push(16'h0A01, 3'd1);
    push(16'h0A02, 3'd2);
    push(16'h0A03, 3'd3);
    n_vec++; if (level !== 3'd3) begin n_bad++; $display("FAIL flush_pre_level got %0d want 3", level); end
    flush = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF; in_dest = 3'd7; out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_vec++; if (level !== 3'd0 || out_valid !== 1'b0 || pending !== 8'h00) begin
      n_bad++; $display("FAIL flush_post got level=%0d v=%b pend=%h want level=0 v=0 pend=00",
                        level, out_valid, pending);
    end
    push(16'h1234, 3'd2);
    n_vec++; if (out_data !== 16'h1234 || out_dest !== 3'd2 || level !== 3'd1) begin
      n_bad++; $display("FAIL flush_after_push got d=%h r=%0d level=%0d want d=1234 r=2 level=1",
                        out_data, out_dest, level);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_dest = '0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
    test_reset();
    test_single();
    test_fill();
    test_dup_dest();
    test_stream();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_res_wb
